cci_mpf_shim_c1_pkt_buffer: RTL and testbench
=============================================

// Module: cci_mpf_shim_c1_pkt_buffer
// PURPOSE
//  Channel-1 Tx stage directly upstream of the CCI-P wire mapping. Buffers AFU write beats.
//  Forwards a multi-beat write (cl_len+1 beats) toward the FIU only once every beat is held.
//  Emits the beats on consecutive cycles, so beats of one packet are never split by FIU backpressure.
//  Also converts FIU c1TxAlmFull into AFU-side almost-full with slack for buffered traffic.
// PARAMETERS
//  DEPTH          64  beat slots; power of 2, >= 16
//  ALMFULL_SLACK  8   afu_c1TxAlmFull asserts when free slots <= ALMFULL_SLACK
// PORTS
//  clk              in   1    sole clock (CCI-P pClk domain)
//  reset            in   1    synchronous, active-high
//  afu_c1_tx        in   t_if_cci_mpf_c1_Tx  request from AFU/MPF shims
//  afu_c1TxAlmFull  out  1    almost-full to AFU
//  fiu_c1_tx        out  t_if_cci_mpf_c1_Tx  request toward FIU wire stage
//  fiu_c1TxAlmFull  in   1    almost-full from FIU
//  pkt_error        out  1    sticky protocol error (see CONFIGURATION)
// BEHAVIOUR
//  Reset: flush FIFO, occupancy=0, complete_pkts=0, in_beat=0, state=IDLE.
//   fiu_c1_tx.valid=0, pkt_error=0. afu_c1TxAlmFull=1 during reset; it may drop from the first cycle after.
//  Enqueue: every cycle afu_c1_tx.valid=1 writes hdr+data into FIFO, no handshake.
//   A write beat advances in_beat (2b). Packet end: in_beat==cl_len, then in_beat<=0.
//   A non-write request (fence/intr) is a 1-beat packet; it takes no part in in_beat.
//   complete_pkts increments on every packet-end enqueue.
//   cl_len legal values: 0,1,3 (eCL_LEN_1/2/4). Value 2 is illegal.
//  Dequeue FSM, registered output:
//   IDLE: complete_pkts!=0 && !fiu_c1TxAlmFull -> SEND. Present head beat on fiu_c1_tx next cycle.
//   SEND: one beat per cycle, ignoring fiu_c1TxAlmFull. CCI-P tolerates <=4 beats after almfull.
//    On the last beat of a packet, stay in SEND if another complete packet exists and !fiu_c1TxAlmFull.
//    Otherwise go to IDLE.
//   complete_pkts decrements on the cycle a packet-end beat is dequeued.
//  Latency: a 1-beat packet enqueued in cycle N with the FIFO empty drives fiu_c1_tx.valid in cycle N+2.
//   For a 4-beat packet, first beat out 2 cycles after its last beat in.
//  Simultaneous enqueue+dequeue: occupancy unchanged. Simultaneous complete inc+dec: complete_pkts unchanged.
//  afu_c1TxAlmFull registered: 1 when (DEPTH-occupancy) <= ALMFULL_SLACK, else 0.
//  Overflow: a beat arriving with FIFO full is dropped and not counted.
//  Order: strict FIFO; fiu_c1_tx headers and data are bit-identical to their input.
//  Reset mid-packet: partial and complete packets are discarded; no beat emitted after reset.
// CONFIGURATION
//  CCI_MPF_C1_PKT_CHECK_EN defined:
//   pkt_error sets and holds until reset on any of:
//    - sop mismatched with (in_beat==0)
//    - cl_len changed mid-packet
//    - cl_len==2
//    - overflow drop
//   Also emits $fatal in simulation.
//  Undefined: pkt_error tied 0; checks are not built. Overflow still drops silently.
// STRUCTURE
//  Package cci_mpf_c1_pkt_pkg:
//   t_c1_pkt_state enum {C1_PKT_IDLE, C1_PKT_SEND}
//   t_c1_beat_idx (2b)
//   function c1_pkt_is_last(hdr, beat_idx)
//  Sub-module cci_mpf_c1_pkt_fifo: DEPTH x {hdr,data} storage with occupancy count.
//  The top level holds the packet counter, FSM and checks.
// TESTING
//  1. Single 1-beat write, FIFO empty, almfull=0 -> fiu valid exactly 2 cycles after input, payload identical.
//  2. 4-beat write with 1-cycle gaps between beats -> no fiu output until beat 3 enqueued.
//     Then 4 consecutive valid beats with sop=1,0,0,0.
//  3. Hold fiu_c1TxAlmFull=1 while a 4-beat packet is ready -> nothing sent. Deassert -> 4 back-to-back beats.
//     Raise almfull after beat 1 -> beats 2-4 still sent.
//  4. Fill to 56/64 beats, no drain -> afu_c1TxAlmFull=1 from occupancy 56. Drain to 55 -> 0 the next cycle.
//  5. Assert reset after beat 2 of a 4-beat packet -> fiu valid=0 and FIFO empty.
//     A fresh 1-beat write then passes normally.
//  6. CHECK_EN: send cl_len=2, or sop=0 on beat 0 -> pkt_error=1 and sticky. Without the macro pkt_error stays 0.

Source files
------------

// File: rtl/cci_mpf_c1_pkt_pkg.sv
// rtl/cci_mpf_c1_pkt_pkg.sv - channel-1 packet buffer types, states and beat helpers
package cci_mpf_c1_pkt_pkg;

  localparam int C1_DATA_W = 512;

  typedef enum logic [2:0] {
    eREQ_WRLINE_I = 3'd0,
    eREQ_WRLINE_M = 3'd1,
    eREQ_WRPUSH_I = 3'd2,
    eREQ_WRFENCE  = 3'd4,
    eREQ_INTR     = 3'd6
  } t_c1_req;

  typedef logic [1:0] t_c1_beat_idx;

  typedef enum logic {C1_PKT_IDLE, C1_PKT_SEND} t_c1_pkt_state;

  typedef struct packed {
    t_c1_req      req_type;
    logic         sop;
    t_c1_beat_idx cl_len;
    logic [41:0]  addr;
    logic [15:0]  mdata;
  } t_c1_hdr;

  typedef struct packed {
    t_c1_hdr                hdr;
    logic [C1_DATA_W-1:0]   data;
    logic                   valid;
  } t_if_cci_mpf_c1_Tx;

  function automatic logic c1_req_is_write(t_c1_hdr hdr);
    return hdr.req_type inside {eREQ_WRLINE_I, eREQ_WRLINE_M, eREQ_WRPUSH_I};
  endfunction

  // Fences and interrupts are always single-beat packets.
  function automatic logic c1_pkt_is_last(t_c1_hdr hdr, t_c1_beat_idx beat_idx);
    return !c1_req_is_write(hdr) || (beat_idx == hdr.cl_len);
  endfunction

endpackage

// File: rtl/cci_mpf_c1_pkt_fifo.sv
// rtl/cci_mpf_c1_pkt_fifo.sv - DEPTH x {hdr,data} beat storage with occupancy count
module cci_mpf_c1_pkt_fifo
  import cci_mpf_c1_pkt_pkg::*;
#(
  parameter int DEPTH = 64
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       i_wr_en,
  input  t_c1_hdr                    i_wr_hdr,
  input  logic [C1_DATA_W-1:0]       i_wr_data,
  output logic                       o_wr_accept,
  input  logic                       i_rd_en,
  output t_c1_hdr                    o_rd_hdr,
  output logic [C1_DATA_W-1:0]       o_rd_data,
  output logic [$clog2(DEPTH):0]     o_count
);

  localparam int AW = $clog2(DEPTH);

  t_c1_hdr              r_hdr_mem  [DEPTH];
  logic [C1_DATA_W-1:0] r_data_mem [DEPTH];
  logic [AW-1:0]        r_wr_ptr;
  logic [AW-1:0]        r_rd_ptr;
  logic [AW:0]          r_count;

  assign o_wr_accept = i_wr_en && (r_count != (AW+1)'(DEPTH));
  assign o_rd_hdr    = r_hdr_mem[r_rd_ptr];
  assign o_rd_data   = r_data_mem[r_rd_ptr];
  assign o_count     = r_count;

  always_ff @(posedge clk) begin
    if (o_wr_accept) begin
      r_hdr_mem[r_wr_ptr]  <= i_wr_hdr;
      r_data_mem[r_wr_ptr] <= i_wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (o_wr_accept) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (i_rd_en)     r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({o_wr_accept, i_rd_en})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/cci_mpf_shim_c1_pkt_buffer.sv
// rtl/cci_mpf_shim_c1_pkt_buffer.sv - whole-packet C1 Tx buffer; CCI_MPF_C1_PKT_CHECK_EN adds protocol checks
module cci_mpf_shim_c1_pkt_buffer
  import cci_mpf_c1_pkt_pkg::*;
#(
  parameter int DEPTH         = 64,
  parameter int ALMFULL_SLACK = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  t_if_cci_mpf_c1_Tx afu_c1_tx,
  output logic              afu_c1TxAlmFull,
  output t_if_cci_mpf_c1_Tx fiu_c1_tx,
  input  logic              fiu_c1TxAlmFull,
  output logic              pkt_error
);

  localparam int AW = $clog2(DEPTH);

  t_c1_pkt_state        r_state;
  t_c1_beat_idx         r_in_beat;
  t_c1_beat_idx         r_out_beat;
  logic [AW:0]          r_complete;
  logic                 r_almfull;
  t_if_cci_mpf_c1_Tx    r_fiu_tx;

  logic                 w_enq_ok;
  t_c1_hdr              w_head_hdr;
  logic [C1_DATA_W-1:0] w_head_data;
  logic [AW:0]          w_count;
  logic [AW:0]          w_free;
  logic                 w_in_write;
  logic                 w_in_last;
  logic                 w_enq_end;
  logic                 w_head_last;
  logic                 w_deq;
  logic                 w_deq_end;

  cci_mpf_c1_pkt_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk         (clk),
    .reset       (reset),
    .i_wr_en     (afu_c1_tx.valid),
    .i_wr_hdr    (afu_c1_tx.hdr),
    .i_wr_data   (afu_c1_tx.data),
    .o_wr_accept (w_enq_ok),
    .i_rd_en     (w_deq),
    .o_rd_hdr    (w_head_hdr),
    .o_rd_data   (w_head_data),
    .o_count     (w_count)
  );

  assign w_in_write  = c1_req_is_write(afu_c1_tx.hdr);
  assign w_in_last   = c1_pkt_is_last(afu_c1_tx.hdr, r_in_beat);
  assign w_enq_end   = w_enq_ok && w_in_last;
  assign w_head_last = c1_pkt_is_last(w_head_hdr, r_out_beat);
  // Once a packet has started, its remaining beats are already buffered, so SEND never stalls.
  assign w_deq       = (r_state == C1_PKT_IDLE) ? ((r_complete != '0) && !fiu_c1TxAlmFull) : 1'b1;
  assign w_deq_end   = w_deq && w_head_last;
  assign w_free      = (AW+1)'(DEPTH) - w_count;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= C1_PKT_IDLE;
      r_in_beat  <= '0;
      r_out_beat <= '0;
      r_complete <= '0;
      r_almfull  <= 1'b1;
      r_fiu_tx   <= '0;
    end else begin
      if (w_enq_ok && w_in_write) r_in_beat <= w_in_last ? '0 : r_in_beat + 2'd1;
      case ({w_enq_end, w_deq_end})
        2'b10:   r_complete <= r_complete + (AW+1)'(1);
        2'b01:   r_complete <= r_complete - (AW+1)'(1);
        default: r_complete <= r_complete;
      endcase
      if (w_deq) begin
        r_out_beat <= w_head_last ? '0 : r_out_beat + 2'd1;
        r_fiu_tx   <= '{hdr: w_head_hdr, data: w_head_data, valid: 1'b1};
        r_state    <= (!w_head_last || ((r_complete > (AW+1)'(1)) && !fiu_c1TxAlmFull))
                      ? C1_PKT_SEND : C1_PKT_IDLE;
      end else begin
        r_fiu_tx.valid <= 1'b0;
      end
      r_almfull <= (w_free <= (AW+1)'(ALMFULL_SLACK));
    end
  end

  assign afu_c1TxAlmFull = r_almfull;
  assign fiu_c1_tx       = r_fiu_tx;

`ifdef CCI_MPF_C1_PKT_CHECK_EN
  t_c1_beat_idx r_pkt_cl_len;
  logic         r_pkt_error;
  logic         w_chk_err;

  always_comb begin
    w_chk_err = 1'b0;
    if (afu_c1_tx.valid) begin
      if (!w_enq_ok) w_chk_err = 1'b1;
      if (w_in_write) begin
        if (afu_c1_tx.hdr.sop != (r_in_beat == '0))                        w_chk_err = 1'b1;
        if ((r_in_beat != '0) && (afu_c1_tx.hdr.cl_len != r_pkt_cl_len)) w_chk_err = 1'b1;
        if (afu_c1_tx.hdr.cl_len == 2'd2)                                   w_chk_err = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_pkt_error  <= 1'b0;
      r_pkt_cl_len <= '0;
    end else begin
      if (w_chk_err) r_pkt_error <= 1'b1;
      if (w_enq_ok && w_in_write && (r_in_beat == '0)) r_pkt_cl_len <= afu_c1_tx.hdr.cl_len;
    end
  end

`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (!reset && w_chk_err) $fatal(1, "cci_mpf_shim_c1_pkt_buffer: C1 packet protocol error");
  end
`endif

  assign pkt_error = r_pkt_error;
`else
  assign pkt_error = 1'b0;
`endif

endmodule

// File: tb/tb_cci_mpf_shim_c1_pkt_buffer.sv
// tb/tb_cci_mpf_shim_c1_pkt_buffer.sv - directed scoreboard bench for the C1 packet buffer
module tb_cci_mpf_shim_c1_pkt_buffer;
  import cci_mpf_c1_pkt_pkg::*;

  logic              clk = 1'b0;
  logic              reset;
  t_if_cci_mpf_c1_Tx afu_tx;
  t_if_cci_mpf_c1_Tx fiu_tx;
  logic              afu_af;
  logic              fiu_af;
  logic              pkt_err;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int out_count = 0;
  int last_drive_cyc = 0;
  int base;
  int expect_err;

  t_if_cci_mpf_c1_Tx sb[$];
  int                out_cycs[$];

  always #5 clk = ~clk;

  cci_mpf_shim_c1_pkt_buffer #(.DEPTH(64), .ALMFULL_SLACK(8)) dut (
    .clk             (clk),
    .reset           (reset),
    .afu_c1_tx       (afu_tx),
    .afu_c1TxAlmFull (afu_af),
    .fiu_c1_tx       (fiu_tx),
    .fiu_c1TxAlmFull (fiu_af),
    .pkt_error       (pkt_err)
  );

  always @(posedge clk) cyc <= cyc + 1;

  always begin
    @(posedge clk);
    #1;
    if (!reset && fiu_tx.valid) begin
      out_count++;
      out_cycs.push_back(cyc);
      checks++;
      if (sb.size() == 0) begin
        failures++;
        $error("FAIL sb_unexpected obs_hdr=%h exp=none", fiu_tx.hdr);
      end else begin
        t_if_cci_mpf_c1_Tx exp_beat;
        exp_beat = sb.pop_front();
        assert (fiu_tx === exp_beat) else begin
          failures++;
          $error("FAIL sb_payload obs_hdr=%h obs_data=%h exp_hdr=%h exp_data=%h",
                 fiu_tx.hdr, fiu_tx.data, exp_beat.hdr, exp_beat.data);
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  function automatic t_c1_hdr mk(input t_c1_req rt, input logic [1:0] len, input logic sop,
                                 input logic [41:0] a);
    t_c1_hdr h;
    h.req_type = rt;
    h.cl_len   = len;
    h.sop      = sop;
    h.addr     = a;
    h.mdata    = a[15:0];
    return h;
  endfunction

  task automatic beat(input t_c1_hdr h);
    t_if_cci_mpf_c1_Tx b;
    b.hdr = h;
    for (int i = 0; i < 16; i++) b.data[i*32 +: 32] = $urandom();
    b.valid = 1'b1;
    afu_tx = b;
    sb.push_back(b);
    last_drive_cyc = cyc;
    @(negedge clk);
    afu_tx.valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_out(input string tag, input int target);
    int k = 0;
    while (out_count < target && k < 200) begin
      @(negedge clk);
      k++;
    end
    chk(tag, 64'(out_count), 64'(target));
  endtask

  initial begin
    reset  = 1'b1;
    afu_tx = '0;
    fiu_af = 1'b0;
    idle(3);
    chk("rst_fiu_valid", 64'(fiu_tx.valid), 64'd0);
    chk("rst_afu_almfull", 64'(afu_af), 64'd1);
    chk("rst_pkt_error", 64'(pkt_err), 64'd0);
    reset = 1'b0;
    idle(2);
    chk("post_rst_almfull", 64'(afu_af), 64'd0);

    // 1: single-beat write, latency 2
    out_cycs.delete();
    base = out_count;
    beat(mk(eREQ_WRLINE_I, 2'd0, 1'b1, 42'h100));
    wait_out("t1_out", base + 1);
    chk("t1_latency", 64'(out_cycs[0]), 64'(last_drive_cyc + 2));

    // 2: 4-beat write with gaps
    out_cycs.delete();
    base = out_count;
    beat(mk(eREQ_WRLINE_M, 2'd3, 1'b1, 42'h200)); idle(1);
    beat(mk(eREQ_WRLINE_M, 2'd3, 1'b0, 42'h201)); idle(1);
    beat(mk(eREQ_WRLINE_M, 2'd3, 1'b0, 42'h202)); idle(1);
    chk("t2_no_early", 64'(out_count), 64'(base));
    beat(mk(eREQ_WRLINE_M, 2'd3, 1'b0, 42'h203));
    wait_out("t2_out", base + 4);
    chk("t2_first_lat", 64'(out_cycs[0]), 64'(last_drive_cyc + 2));
    chk("t2_consecutive", 64'(out_cycs[3]), 64'(out_cycs[0] + 3));

    // 3: FIU almost-full holds a ready packet, then mid-packet almfull does not split it
    fiu_af = 1'b1;
    base = out_count;
    for (int i = 0; i < 4; i++) beat(mk(eREQ_WRPUSH_I, 2'd3, (i == 0), 42'h300 + 42'(i)));
    idle(10);
    chk("t3_held", 64'(out_count), 64'(base));
    out_cycs.delete();
    fiu_af = 1'b0;
    wait_out("t3_release", base + 4);
    chk("t3_b2b", 64'(out_cycs[3]), 64'(out_cycs[0] + 3));
    base = out_count;
    for (int i = 0; i < 4; i++) beat(mk(eREQ_WRLINE_I, 2'd3, (i == 0), 42'h400 + 42'(i)));
    wait_out("t3_first", base + 1);
    fiu_af = 1'b1;
    idle(8);
    chk("t3_rest_sent", 64'(out_count), 64'(base + 4));
    fiu_af = 1'b0;

    // 4: AFU almost-full threshold at 56 of 64
    idle(4);
    fiu_af = 1'b1;
    base = out_count;
    for (int i = 0; i < 55; i++) beat(mk(eREQ_WRLINE_I, 2'd0, 1'b1, 42'h1000 + 42'(i)));
    idle(2);
    chk("t4_af_at55", 64'(afu_af), 64'd0);
    beat(mk(eREQ_WRLINE_I, 2'd0, 1'b1, 42'h1037));
    @(negedge clk);
    chk("t4_af_at56", 64'(afu_af), 64'd1);
    fiu_af = 1'b0;
    @(negedge clk);
    fiu_af = 1'b1;
    idle(3);
    chk("t4_pulse_drain", 64'(out_count), 64'(base + 2));
    chk("t4_af_drop", 64'(afu_af), 64'd0);
    fiu_af = 1'b0;
    wait_out("t4_drain_all", base + 56);

    // 5: reset with a held complete packet and a partial packet in flight
    fiu_af = 1'b1;
    beat(mk(eREQ_WRLINE_I, 2'd0, 1'b1, 42'h500));
    beat(mk(eREQ_WRLINE_I, 2'd3, 1'b1, 42'h510));
    beat(mk(eREQ_WRLINE_I, 2'd3, 1'b0, 42'h511));
    base = out_count;
    reset = 1'b1;
    sb.delete();
    @(negedge clk);
    chk("t5_rst_valid", 64'(fiu_tx.valid), 64'd0);
    chk("t5_rst_af", 64'(afu_af), 64'd1);
    reset  = 1'b0;
    fiu_af = 1'b0;
    idle(5);
    chk("t5_nothing_out", 64'(out_count), 64'(base));
    chk("t5_af_clear", 64'(afu_af), 64'd0);
    out_cycs.delete();
    beat(mk(eREQ_WRLINE_M, 2'd0, 1'b1, 42'h600));
    wait_out("t5_fresh", base + 1);
    chk("t5_fresh_lat", 64'(out_cycs[0]), 64'(last_drive_cyc + 2));

    // 6: protocol violations
`ifdef CCI_MPF_C1_PKT_CHECK_EN
    expect_err = 1;
`else
    expect_err = 0;
`endif
    base = out_count;
    beat(mk(eREQ_WRLINE_I, 2'd0, 1'b0, 42'h700));
    beat(mk(eREQ_WRLINE_I, 2'd2, 1'b1, 42'h710));
    beat(mk(eREQ_WRLINE_I, 2'd2, 1'b0, 42'h711));
    beat(mk(eREQ_WRLINE_I, 2'd2, 1'b0, 42'h712));
    beat(mk(eREQ_WRFENCE, 2'd0, 1'b1, 42'h0));
    wait_out("t6_out", base + 5);
    chk("t6_pkt_error", 64'(pkt_err), 64'(expect_err));
    idle(3);
    chk("t6_sticky", 64'(pkt_err), 64'(expect_err));
    chk("sb_empty", 64'(sb.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
